// File: rtl/dp_pkg.sv
// rtl/dp_pkg.sv - shared types and constants for the datapath execution unit
package dp_pkg;

  typedef enum logic [1:0] {
    KIND_ALU  = 2'd0,
    KIND_MOVI = 2'd1,
    KIND_MOVR = 2'd2,
    KIND_CMP  = 2'd3
  } kind_e;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_AND  = 2'd2,
    OP_NOTB = 2'd3
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'd0,
    SH_LSL1 = 2'd1,
    SH_LSR1 = 2'd2,
    SH_ASR1 = 2'd3
  } shift_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LDB  = 3'd1,
    ST_LDA  = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4
  } state_e;

  // Bit positions inside the {N, V, Z} status word
  localparam int STATUS_N = 2;
  localparam int STATUS_V = 1;
  localparam int STATUS_Z = 0;

endpackage

// File: rtl/dp_regfile.sv
// rtl/dp_regfile.sv - register file with one write, one operand read and one debug read port
module dp_regfile #(
  parameter int W    = 16,
  parameter int NREG = 8,
  localparam int RA  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [RA-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [RA-1:0] raddr,
  output logic [W-1:0]  rdata,
  input  logic [RA-1:0] dbg_addr,
  output logic [W-1:0]  dbg_data
);

  logic [W-1:0] mem [NREG];

  // Reads are combinational so operand loads see the value held at that edge
  assign rdata    = mem[raddr];
  assign dbg_data = mem[dbg_addr];

  // Write port; reset clears every entry
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/dp_exec_unit.sv
// rtl/dp_exec_unit.sv - multi-cycle load/execute/writeback datapath with flags
module dp_exec_unit
  import dp_pkg::*;
#(
  parameter int W    = 16,
  parameter int NREG = 8,
  localparam int RA  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    kind,
  input  logic [1:0]    alu_op,
  input  logic [1:0]    shift,
  input  logic [RA-1:0] rd,
  input  logic [RA-1:0] rn,
  input  logic [RA-1:0] rm,
  input  logic [W-1:0]  imm,
  input  logic          set_flags,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  datapath_out,
  output logic [2:0]    status,
  input  logic [RA-1:0] dbg_addr,
  output logic [W-1:0]  dbg_data
);

  state_e        state;
  kind_e         kind_q;
  alu_op_e       op_q;
  shift_e        shift_q;
  logic [RA-1:0] rd_q, rn_q, rm_q;
  logic [W-1:0]  imm_q;
  logic          sf_q;
  logic [W-1:0]  a_q, b_q, c_q;
  logic [2:0]    status_q;

  logic [RA-1:0] rf_raddr;
  logic [W-1:0]  rf_rdata;
  logic          rf_we;
  logic [W-1:0]  rf_wdata;

  logic [W-1:0]  b_sh, a_eff, sum, diff, result;
  alu_op_e       op_eff;
  logic          ovf;

  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_WB);
  assign datapath_out = c_q;
  assign status       = status_q;

  // B comes from rm in LDB, A from rn in LDA
  assign rf_raddr = (state == ST_LDB) ? rm_q : rn_q;
  assign rf_we    = (state == ST_WB) && (kind_q != KIND_CMP);
  assign rf_wdata = (kind_q == KIND_MOVI) ? imm_q : c_q;

  // MOVR is executed as 0 + sh(B)
  assign a_eff  = (kind_q == KIND_MOVR) ? '0 : a_q;
  assign op_eff = (kind_q == KIND_MOVR) ? OP_ADD : op_q;
  assign sum    = a_eff + b_sh;
  assign diff   = a_eff - b_sh;

  // Barrel-free single-bit shifter on the B operand
  always_comb begin
    b_sh = b_q;
    case (shift_q)
      SH_LSL1: b_sh = {b_q[W-2:0], 1'b0};
      SH_LSR1: b_sh = {1'b0, b_q[W-1:1]};
      SH_ASR1: b_sh = {b_q[W-1], b_q[W-1:1]};
      default: b_sh = b_q;
    endcase
  end

  // ALU result and signed overflow (only meaningful for ADD/SUB)
  always_comb begin
    result = sum;
    ovf    = 1'b0;
    case (op_eff)
      OP_ADD: begin
        result = sum;
        ovf    = (a_eff[W-1] == b_sh[W-1]) && (sum[W-1] != a_eff[W-1]);
      end
      OP_SUB: begin
        result = diff;
        ovf    = (a_eff[W-1] != b_sh[W-1]) && (diff[W-1] != a_eff[W-1]);
      end
      OP_AND:  result = a_eff & b_sh;
      OP_NOTB: result = ~b_sh;
      default: result = sum;
    endcase
  end

  // Sequencer, operand capture and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      kind_q   <= KIND_ALU;
      op_q     <= OP_ADD;
      shift_q  <= SH_NONE;
      rd_q     <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      imm_q    <= '0;
      sf_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            kind_q  <= kind_e'(kind);
            op_q    <= alu_op_e'(alu_op);
            shift_q <= shift_e'(shift);
            rd_q    <= rd;
            rn_q    <= rn;
            rm_q    <= rm;
            imm_q   <= imm;
            sf_q    <= set_flags;
            state   <= (kind_e'(kind) == KIND_MOVI) ? ST_WB : ST_LDB;
          end
        end
        ST_LDB: begin
          b_q   <= rf_rdata;
          state <= (kind_q == KIND_MOVR) ? ST_EXEC : ST_LDA;
        end
        ST_LDA: begin
          a_q   <= rf_rdata;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          c_q <= result;
          if (sf_q) begin
            status_q[STATUS_N] <= result[W-1];
            status_q[STATUS_V] <= ovf;
            status_q[STATUS_Z] <= (result == '0);
          end
          state <= ST_WB;
        end
        ST_WB: begin
          if (kind_q == KIND_MOVI) c_q <= imm_q;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  dp_regfile #(.W(W), .NREG(NREG)) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we       (rf_we),
    .waddr    (rd_q),
    .wdata    (rf_wdata),
    .raddr    (rf_raddr),
    .rdata    (rf_rdata),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

endmodule

// File: tb/tb_dp_exec_unit.sv
// tb/tb_dp_exec_unit.sv - directed self-checking bench for dp_exec_unit at W=16/NREG=8 and W=32/NREG=16
module tb_dp_exec_unit;

  logic        clk = 1'b0;
  logic        reset, start, sel, set_flags;
  logic [1:0]  kind, alu_op, shift;
  logic [3:0]  rd, rn, rm, dbg_addr;
  logic [31:0] imm;

  logic        start16, start32;
  logic        busy16, done16, busy32, done32;
  logic [15:0] out16, dbg16;
  logic [31:0] out32, dbg32;
  logic [2:0]  status16, status32;

  logic        busy_s, done_s;
  logic [31:0] out_s, dbg_s;
  logic [2:0]  status_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign start16  = start & ~sel;
  assign start32  = start & sel;
  assign busy_s   = sel ? busy32 : busy16;
  assign done_s   = sel ? done32 : done16;
  assign out_s    = sel ? out32 : {16'h0, out16};
  assign dbg_s    = sel ? dbg32 : {16'h0, dbg16};
  assign status_s = sel ? status32 : status16;

  dp_exec_unit #(.W(16), .NREG(8)) u_dut16 (
    .clk          (clk),
    .reset        (reset),
    .start        (start16),
    .kind         (kind),
    .alu_op       (alu_op),
    .shift        (shift),
    .rd           (rd[2:0]),
    .rn           (rn[2:0]),
    .rm           (rm[2:0]),
    .imm          (imm[15:0]),
    .set_flags    (set_flags),
    .busy         (busy16),
    .done         (done16),
    .datapath_out (out16),
    .status       (status16),
    .dbg_addr     (dbg_addr[2:0]),
    .dbg_data     (dbg16)
  );

  dp_exec_unit #(.W(32), .NREG(16)) u_dut32 (
    .clk          (clk),
    .reset        (reset),
    .start        (start32),
    .kind         (kind),
    .alu_op       (alu_op),
    .shift        (shift),
    .rd           (rd),
    .rn           (rn),
    .rm           (rm),
    .imm          (imm),
    .set_flags    (set_flags),
    .busy         (busy32),
    .done         (done32),
    .datapath_out (out32),
    .status       (status32),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg32)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] k, input logic [1:0] op, input logic [1:0] sh,
                       input logic [3:0] d, input logic [3:0] n, input logic [3:0] m,
                       input logic [31:0] im, input logic sf);
    kind = k; alu_op = op; shift = sh;
    rd = d; rn = n; rm = m; imm = im; set_flags = sf;
  endtask

  task automatic run_op(input string tag, input logic [1:0] k, input logic [1:0] op,
                        input logic [1:0] sh, input logic [3:0] d, input logic [3:0] n,
                        input logic [3:0] m, input logic [31:0] im, input logic sf,
                        input int exp_lat);
    int c;
    @(negedge clk);
    drive(k, op, sh, d, n, m, im, sf);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drive(2'd0, 2'd0, 2'd0, 4'd0, 4'd0, 4'd0, 32'h0, 1'b0);
    c = 1;
    while (!done_s && c < 10) begin
      @(posedge clk); #1;
      c++;
    end
    check({tag, " latency"}, 32'(c), 32'(exp_lat));
    @(posedge clk); #1;
    check({tag, " idle after wb"}, {31'h0, busy_s}, 32'h0);
  endtask

  task automatic movi(input logic [3:0] d, input logic [31:0] v);
    run_op("movi", 2'd1, 2'd0, 2'd0, d, 4'd0, 4'd0, v, 1'b0, 1);
  endtask

  task automatic check_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
    @(negedge clk);
    dbg_addr = a;
    #1;
    check(tag, dbg_s, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Main directed sequence
  initial begin
    int pulses;
    reset = 1'b1; start = 1'b0; sel = 1'b0; dbg_addr = 4'd0;
    drive(2'd0, 2'd0, 2'd0, 4'd0, 4'd0, 4'd0, 32'h0, 1'b0);
    do_reset();

    // Reset state, 16-bit instance
    #1;
    check("rst busy", {31'h0, busy_s}, 32'h0);
    check("rst done", {31'h0, done_s}, 32'h0);
    check("rst out", out_s, 32'h0);
    check("rst status", {29'h0, status_s}, 32'h0);
    for (int i = 0; i < 8; i++) check_reg("rst reg", 4'(i), 32'h0);

    // MOVI R3,42; MOVI R5,13; ADD R2,R5,R3
    movi(4'd3, 32'd42);
    check("movi out", out_s, 32'd42);
    movi(4'd5, 32'd13);
    run_op("add r2", 2'd0, 2'd0, 2'd0, 4'd2, 4'd5, 4'd3, 32'h0, 1'b0, 4);
    check_reg("r2 sum", 4'd2, 32'd55);
    check("add out", out_s, 32'd55);

    // AND with LSR1 on B, then NOT B
    movi(4'd1, 32'd10);
    movi(4'd2, 32'd20);
    run_op("and lsr", 2'd0, 2'd2, 2'd2, 4'd0, 4'd2, 4'd1, 32'h0, 1'b0, 4);
    check_reg("r0 and", 4'd0, 32'd4);
    run_op("notb", 2'd0, 2'd3, 2'd0, 4'd4, 4'd0, 4'd0, 32'h0, 1'b0, 4);
    check_reg("r4 notb", 4'd4, 32'hFFFB);

    // Signed overflow on ADD
    movi(4'd4, 32'h7FFF);
    movi(4'd6, 32'd1);
    run_op("add ovf", 2'd0, 2'd0, 2'd0, 4'd7, 4'd4, 4'd6, 32'h0, 1'b1, 4);
    check_reg("r7 ovf", 4'd7, 32'h8000);
    check("status nvz ovf", {29'h0, status_s}, 32'h6);

    // CMP via SUB then ADD
    movi(4'd4, 32'hFFFC);
    movi(4'd6, 32'd4);
    run_op("cmp sub", 2'd3, 2'd1, 2'd0, 4'd7, 4'd4, 4'd6, 32'h0, 1'b1, 4);
    check("cmp sub status", {29'h0, status_s}, 32'h4);
    check("cmp sub out", out_s, 32'hFFF8);
    run_op("cmp add", 2'd3, 2'd0, 2'd0, 4'd7, 4'd4, 4'd6, 32'h0, 1'b1, 4);
    check("cmp add status", {29'h0, status_s}, 32'h1);
    check_reg("cmp r7 kept", 4'd7, 32'h8000);
    check_reg("cmp r4 kept", 4'd4, 32'hFFFC);
    check_reg("cmp r6 kept", 4'd6, 32'd4);

    // MOVR with shifts; status untouched without set_flags
    movi(4'd4, 32'h8000);
    run_op("movr asr", 2'd2, 2'd3, 2'd3, 4'd0, 4'd5, 4'd4, 32'h0, 1'b0, 3);
    check_reg("r0 asr", 4'd0, 32'hC000);
    check("status held", {29'h0, status_s}, 32'h1);
    run_op("movr lsl", 2'd2, 2'd0, 2'd1, 4'd1, 4'd0, 4'd6, 32'h0, 1'b0, 3);
    check_reg("r1 lsl", 4'd1, 32'd8);
    run_op("movr lsr", 2'd2, 2'd0, 2'd2, 4'd3, 4'd0, 4'd4, 32'h0, 1'b0, 3);
    check_reg("r3 lsr", 4'd3, 32'h4000);
    run_op("add self", 2'd0, 2'd0, 2'd0, 4'd6, 4'd6, 4'd6, 32'h0, 1'b0, 4);
    check_reg("r6 self", 4'd6, 32'd8);

    // start during LDA is ignored: exactly one done, injected MOVI never lands
    @(negedge clk);
    drive(2'd0, 2'd0, 2'd0, 4'd2, 4'd1, 4'd6, 32'h0, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    drive(2'd1, 2'd0, 2'd0, 4'd3, 4'd0, 4'd0, 32'h1234, 1'b0);
    start = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i == 0) start = 1'b0;
      if (done_s) pulses++;
    end
    check("busy start pulses", 32'(pulses), 32'd1);
    check_reg("busy start r2", 4'd2, 32'd16);
    check_reg("busy start r3", 4'd3, 32'h4000);

    // Reset in EXEC, with start also asserted
    @(negedge clk);
    drive(2'd0, 2'd0, 2'd0, 4'd5, 4'd1, 4'd6, 32'h0, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("in exec busy", {31'h0, busy_s}, 32'h1);
    reset = 1'b1;
    start = 1'b1;
    drive(2'd1, 2'd0, 2'd0, 4'd5, 4'd0, 4'd0, 32'h55, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    check("abort busy", {31'h0, busy_s}, 32'h0);
    check("abort done", {31'h0, done_s}, 32'h0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done_s) pulses++;
    end
    check("abort no done", 32'(pulses), 32'd0);
    check("abort out", out_s, 32'h0);
    check("abort status", {29'h0, status_s}, 32'h0);
    for (int i = 0; i < 8; i++) check_reg("abort reg", 4'(i), 32'h0);

    // Wide instance
    @(negedge clk);
    sel = 1'b1;
    do_reset();
    movi(4'd3, 32'd42);
    movi(4'd5, 32'd13);
    run_op("w32 add", 2'd0, 2'd0, 2'd0, 4'd2, 4'd5, 4'd3, 32'h0, 1'b0, 4);
    check_reg("w32 r2", 4'd2, 32'd55);
    movi(4'd9, 32'hFFFF_FFFF);
    movi(4'd10, 32'd1);
    run_op("w32 wrap", 2'd0, 2'd0, 2'd0, 4'd11, 4'd9, 4'd10, 32'h0, 1'b1, 4);
    check_reg("w32 r11", 4'd11, 32'h0);
    check("w32 out", out_s, 32'h0);
    check("w32 status", {29'h0, status_s}, 32'h1);
    movi(4'd8, 32'h8000_0000);
    run_op("w32 asr", 2'd2, 2'd0, 2'd3, 4'd15, 4'd0, 4'd8, 32'h0, 1'b0, 3);
    check_reg("w32 r15", 4'd15, 32'hC000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
